// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared types and helpers for the multi-cycle multiply/divide unit.
//   - muldiv_op_t : 4-bit operation encoding driven by the execute pipe
//   - md_state_t  : control FSM state encoding
//   - WLEN        : width of the "W" (word) operations
//   - op_is_*     : operation class decoders used by the unit
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int WLEN = 32;

    typedef enum logic [3:0] {
        MD_MUL   = 4'd0,
        MD_DIV   = 4'd1,
        MD_DIVU  = 4'd2,
        MD_REM   = 4'd3,
        MD_REMU  = 4'd4,
        MD_MULW  = 4'd5,
        MD_DIVW  = 4'd6,
        MD_DIVUW = 4'd7,
        MD_REMW  = 4'd8,
        MD_REMUW = 4'd9
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    // Word op: 32-bit operands, result sign-extended to XLEN
    function automatic logic op_is_w(input muldiv_op_t op);
        logic r;
        case (op)
            MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Multiply op (low half of the product)
    function automatic logic op_is_mul(input muldiv_op_t op);
        logic r;
        case (op)
            MD_MUL, MD_MULW: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // Signed divide/remainder op
    function automatic logic op_is_signed(input muldiv_op_t op);
        logic r;
        case (op)
            MD_DIV, MD_REM, MD_DIVW, MD_REMW: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Remainder op (returns remainder instead of quotient)
    function automatic logic op_is_rem(input muldiv_op_t op);
        logic r;
        case (op)
            MD_REM, MD_REMU, MD_REMW, MD_REMUW: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-division step. The partial remainder is shifted
// left with the next dividend bit; if the divisor fits, it is subtracted and
// the quotient bit is 1, otherwise the shifted value is kept (restored).
// Ports:
//   i_rem     : current partial remainder (always < divisor)
//   i_bit     : next dividend bit, MSB first
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qbit    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module muldiv_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        if (w_diff[XLEN]) begin
            o_qbit = 1'b0;
            o_rem  = w_shift[XLEN-1:0];
        end else begin
            o_qbit = 1'b1;
            o_rem  = w_diff[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle integer multiply/divide unit for the execute stage. One operation
// in flight at a time; valid/ready on both sides; registered result and tag.
// Division is restoring radix-2 (one bit per cycle). Multiplication is
// MSB-first shift-add over the same registers, or single-cycle when the
// MULDIV_FASTMUL_EN macro is defined. W ops work on the low 32 bits and
// sign-extend the 32-bit result.
//
// Configuration macro: MULDIV_FASTMUL_EN (single-cycle MUL/MULW when defined)
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   flush                   : synchronous cancel of any in-flight op
//   in_valid/in_ready       : request handshake
//   in_op, in_a, in_b       : operation and operands
//   in_tag                  : opaque tag echoed on out_tag
//   out_valid/out_ready     : response handshake
//   out_result, out_tag     : registered result and tag
//   busy                    : unit is not idle
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int              CNT_W  = $clog2(XLEN + 1);
    localparam int              WSHIFT = XLEN - WLEN;
    localparam logic [XLEN-1:0] ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL1   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XMIN   = {1'b1, {(XLEN-1){1'b0}}};

    // Extend the low WLEN bits to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = WLEN; i < XLEN; i++) begin
            r[i] = sgn ? v[WLEN-1] : 1'b0;
        end
        return r;
    endfunction

    // Format a result at the op width (W ops sign-extend bit 31).
    function automatic logic [XLEN-1:0] fit_op(input logic [XLEN-1:0] v, input logic is_w);
        return is_w ? ext_w(v, 1'b1) : v;
    endfunction

    // ---------------- state and datapath registers ----------------
    md_state_t        r_state;
    md_state_t        w_state_next;
    logic             r_out_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;       // partial remainder / product accumulator
    logic [XLEN-1:0]  r_quot;      // dividend (quotient shifts in) / multiplier
    logic [XLEN-1:0]  r_divisor;   // divisor magnitude / multiplicand
    muldiv_op_t       r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_out_result;
    logic [TAG_W-1:0] r_out_tag;

    // ---------------- acceptance-side decode ----------------
    logic             w_in_ready;
    logic             w_accept;
    logic             w_op_w;
    logic             w_op_mul;
    logic             w_op_signed;
    logic             w_op_rem;
    logic [XLEN-1:0]  w_a_ext;
    logic [XLEN-1:0]  w_b_ext;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic [XLEN-1:0]  w_min_op;
    logic             w_short;
    logic [XLEN-1:0]  w_short_res;
    logic [XLEN-1:0]  w_load_quot;
    logic [XLEN-1:0]  w_load_div;
    logic [CNT_W-1:0] w_load_cnt;
`ifdef MULDIV_FASTMUL_EN
    logic [XLEN-1:0]  w_prod;
`endif

    // ---------------- iteration-side signals ----------------
    logic [XLEN-1:0]  w_step_rem;
    logic             w_step_q;
    logic [XLEN-1:0]  w_acc_next;
    logic [XLEN-1:0]  w_q_final;
    logic [XLEN-1:0]  w_q_signed;
    logic [XLEN-1:0]  w_r_signed;
    logic [XLEN-1:0]  w_iter_res;

    assign w_accept = in_valid & w_in_ready;

    // Decode the incoming request: magnitudes, signs, special cases, load values.
    always_comb begin
        w_op_w      = op_is_w(in_op);
        w_op_mul    = op_is_mul(in_op);
        w_op_signed = op_is_signed(in_op);
        w_op_rem    = op_is_rem(in_op);

        w_a_ext  = w_op_w ? ext_w(in_a, w_op_signed) : in_a;
        w_b_ext  = w_op_w ? ext_w(in_b, w_op_signed) : in_b;
        w_a_neg  = w_op_signed & w_a_ext[XLEN-1];
        w_b_neg  = w_op_signed & w_b_ext[XLEN-1];
        // For a signed W op the magnitude is at most 2^31, so the upper bits
        // are clear and the value can be pre-shifted to the top below.
        w_a_mag  = w_a_neg ? (ZERO - w_a_ext) : w_a_ext;
        w_b_mag  = w_b_neg ? (ZERO - w_b_ext) : w_b_ext;

        w_min_op = w_op_w ? (ALL1 << (WLEN - 1)) : XMIN;
        w_b_zero = (w_b_ext == ZERO);
        w_ovf    = w_op_signed & (w_a_ext == w_min_op) & (w_b_ext == ALL1);

        w_short     = 1'b0;
        w_short_res = ZERO;
        if (w_op_mul) begin
`ifdef MULDIV_FASTMUL_EN
            // Low 32 bits of the full product equal the 32x32 product.
            w_prod      = in_a * in_b;
            w_short     = 1'b1;
            w_short_res = fit_op(w_prod, w_op_w);
`else
            w_short     = 1'b0;
            w_short_res = ZERO;
`endif
        end else if (w_b_zero) begin
            w_short     = 1'b1;
            w_short_res = w_op_rem ? fit_op(in_a, w_op_w) : ALL1;
        end else if (w_ovf) begin
            w_short     = 1'b1;
            w_short_res = w_op_rem ? ZERO : w_min_op;
        end else begin
            w_short     = 1'b0;
            w_short_res = ZERO;
        end

        // Word operands are parked in the top half so the MSB-first iteration
        // consumes exactly 32 bits.
        w_load_quot = w_op_mul ? w_b_ext : w_a_mag;
        if (w_op_w) begin
            w_load_quot = w_load_quot << WSHIFT;
        end else begin
            w_load_quot = w_load_quot;
        end
        w_load_div = w_op_mul ? in_a : w_b_mag;
        w_load_cnt = w_op_w ? CNT_W'(WLEN) : CNT_W'(XLEN);
    end

    muldiv_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[XLEN-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Per-cycle multiply step and the final sign fix-up of the last iteration.
    always_comb begin
        w_acc_next = {r_rem[XLEN-2:0], 1'b0} + (r_quot[XLEN-1] ? r_divisor : ZERO);
        w_q_final  = {r_quot[XLEN-2:0], w_step_q};
        w_q_signed = r_neg_q ? (ZERO - w_q_final) : w_q_final;
        w_r_signed = r_neg_r ? (ZERO - w_step_rem) : w_step_rem;
        if (op_is_mul(r_op)) begin
            w_iter_res = fit_op(w_acc_next, op_is_w(r_op));
        end else if (op_is_rem(r_op)) begin
            w_iter_res = fit_op(w_r_signed, op_is_w(r_op));
        end else begin
            w_iter_res = fit_op(w_q_signed, op_is_w(r_op));
        end
    end

    // Next-state logic; flush overrides everything and blocks acceptance.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_state_next = w_short ? S_DONE : S_BUSY;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_BUSY;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State register plus registered status outputs derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == S_DONE);
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Operand latch, iteration registers, and result/tag capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= {CNT_W{1'b0}};
            r_rem        <= ZERO;
            r_quot       <= ZERO;
            r_divisor    <= ZERO;
            r_op         <= MD_MUL;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_out_result <= ZERO;
            r_out_tag    <= {TAG_W{1'b0}};
        end else if (flush) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= in_op;
                        r_out_tag <= in_tag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_rem     <= ZERO;
                        r_quot    <= w_load_quot;
                        r_divisor <= w_load_div;
                        if (w_short) begin
                            r_cnt        <= {CNT_W{1'b0}};
                            r_out_result <= w_short_res;
                        end else begin
                            r_cnt <= w_load_cnt;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem  <= op_is_mul(r_op) ? w_acc_next : w_step_rem;
                    r_quot <= {r_quot[XLEN-2:0], w_step_q};
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_result <= w_iter_res;
                    end
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and randomized checks of muldiv_unit against an arithmetic
// reference model (SystemVerilog integer / and % with the special cases for
// divide-by-zero and signed overflow).
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    muldiv_op_t       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference result from plain arithmetic.
    function automatic logic [63:0] ref_model(input muldiv_op_t op, input logic [63:0] a,
                                              input logic [63:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [63:0]     r;
        sa = a; sb = b; ua = a; ub = b;
        sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        case (op)
            MD_MUL:   r = ua * ub;
            MD_MULW:  r = sx32(32'(ua32 * ub32));
            MD_DIV:   if (sb == 0) r = '1;
                      else if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) r = a;
                      else r = sa / sb;
            MD_REM:   if (sb == 0) r = a;
                      else if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) r = 64'd0;
                      else r = sa % sb;
            MD_DIVU:  r = (ub == 0) ? '1 : ua / ub;
            MD_REMU:  r = (ub == 0) ? a : ua % ub;
            MD_DIVW:  if (sb32 == 0) r = '1;
                      else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r = sx32(32'h8000_0000);
                      else r = sx32(32'(sa32 / sb32));
            MD_REMW:  if (sb32 == 0) r = sx32(a[31:0]);
                      else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r = 64'd0;
                      else r = sx32(32'(sa32 % sb32));
            MD_DIVUW: r = (ub32 == 0) ? '1 : sx32(32'(ua32 / ub32));
            MD_REMUW: r = (ub32 == 0) ? sx32(a[31:0]) : sx32(32'(ua32 % ub32));
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

    // Expected edge count from acceptance to out_valid.
    function automatic int ref_latency(input muldiv_op_t op, input logic [63:0] a,
                                       input logic [63:0] b);
        bit w, is_mul, sgn;
        int n;
        w      = op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
        is_mul = op inside {MD_MUL, MD_MULW};
        sgn    = op inside {MD_DIV, MD_REM, MD_DIVW, MD_REMW};
        n      = w ? 32 : 64;
        if (is_mul) begin
`ifdef MULDIV_FASTMUL_EN
            return 1;
`else
            return n + 1;
`endif
        end
        if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
        if (sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
            return 1;
        return n + 1;
    endfunction

    // Issue one op, measure latency, check result/tag, optionally stall the consumer.
    task automatic run_op(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input int hold);
        logic [63:0] exp_res;
        int          exp_lat;
        int          edges;
        bit          rdy_seen;
        exp_res = ref_model(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        rdy_seen = 1'b0;
        while (!out_valid && edges < 200) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            edges++;
        end
        chk($sformatf("latency op%0d", op), 64'(edges), 64'(exp_lat));
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), out_result, exp_res);
        chk("tag", 64'(out_tag), 64'(tag));
        chk("in_ready_busy", 64'(rdy_seen | in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", out_result, exp_res);
            chk("hold_tag", 64'(out_tag), 64'(tag));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("consumed_valid", 64'(out_valid), 64'd0);
        chk("consumed_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(6, 0))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom_range(100, 0));
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            4:       v = {$urandom, 32'h8000_0000};
            5:       v = 64'd0 - 64'($urandom_range(100, 1));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        bit         seen;
        muldiv_op_t rop;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = MD_MUL;
        in_a = 64'd0; in_b = 64'd0; in_tag = 5'd0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); reset = 1'b0;

        // Directed cases
        run_op(MD_DIVU, 64'd100, 64'd7, 5'd3, 0);
        run_op(MD_REMU, 64'd100, 64'd7, 5'd4, 0);
        run_op(MD_DIV,  64'd0 - 64'd7, 64'd2, 5'd5, 0);
        run_op(MD_REM,  64'd0 - 64'd7, 64'd2, 5'd6, 0);
        run_op(MD_REM,  64'd7, 64'd0 - 64'd2, 5'd7, 0);
        run_op(MD_DIVU, 64'd5, 64'd0, 5'd8, 0);
        run_op(MD_REMU, 64'd5, 64'd0, 5'd9, 0);
        run_op(MD_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10, 0);
        run_op(MD_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11, 0);
        run_op(MD_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 0);
        run_op(MD_MUL,  64'h0000_0000_FFFF_FFFF, 64'd2, 5'd13, 0);
        run_op(MD_MULW, 64'h0000_0000_4000_0000, 64'd2, 5'd14, 0);
        run_op(MD_DIVUW, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 5'd15, 0);
        run_op(MD_DIVU, 64'd1000, 64'd10, 5'd21, 3);

        // Flush on the 10th BUSY cycle with a competing request
        @(negedge clk);
        in_op = MD_DIV; in_a = 64'd0 - 64'd1000; in_b = 64'd3; in_tag = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush_busy_before", 64'(busy), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = MD_DIVU; in_a = 64'd50; in_b = 64'd5; in_tag = 5'd18;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        run_op(MD_DIVU, 64'd9, 64'd3, 5'd19, 0);

        // Asynchronous reset in the middle of an iterative op
        @(negedge clk);
        in_op = MD_DIVU; in_a = 64'd12345; in_b = 64'd11; in_tag = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_result", out_result, 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); reset = 1'b0;

        // Randomized ops against the reference model
        for (int k = 0; k < 30; k++) begin
            rop = muldiv_op_t'(4'($urandom_range(9, 0)));
            run_op(rop, rnd_operand(), rnd_operand(), 5'($urandom_range(31, 0)), (k % 5 == 0) ? 2 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
